// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO decode, STATUS layout,
// default FIFO sizing, and a STATUS packing helper.
package dmem_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned MMIO_BIT           = 31;
  localparam int unsigned REG_SEL_LSB        = 2;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
  localparam int unsigned TX_DATA_W          = 8;

  // MMIO register offsets, selected by addr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_CYCLE  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  // STATUS bit positions
  localparam int unsigned ST_FULL_BIT     = 0;
  localparam int unsigned ST_EMPTY_BIT    = 1;
  localparam int unsigned ST_OVERFLOW_BIT = 2;
  localparam int unsigned ST_COUNT_LSB    = 4;
  localparam int unsigned ST_COUNT_W      = 4;

  // Writing STATUS with this data bit set clears the sticky overflow flag
  localparam int unsigned ST_CLR_OVF_BIT  = 2;

  // Assemble the STATUS read word; unused bits read as zero
  function automatic logic [XLEN-1:0] pack_status(
    input logic [ST_COUNT_W-1:0] count,
    input logic                  overflow,
    input logic                  empty,
    input logic                  full
  );
    logic [XLEN-1:0] s;
    s                                = '0;
    s[ST_COUNT_LSB +: ST_COUNT_W]    = count;
    s[ST_OVERFLOW_BIT]               = overflow;
    s[ST_EMPTY_BIT]                  = empty;
    s[ST_FULL_BIT]                   = full;
    return s;
  endfunction

endpackage

// File: rtl/dmem_tx_fifo.sv
// Synchronous power-of-two FIFO for the console transmit path.
// A push into a full FIFO is accepted only when a pop happens on the same edge;
// otherwise it is silently refused (the parent tracks overflow).
module dmem_tx_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = TX_DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  // Accept/advance decisions and next pointer/count values
  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != CW'(DEPTH)) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and occupancy registers; reset flushes the queue
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy guards them
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Head is forced to zero when empty so the console sees a clean idle value
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    count_o = count_q;
    head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM (combinational read, synchronous write) plus
// an MMIO window with TX FIFO, cycle counter and STATUS register.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN (adds the free-running CYCLE counter).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_wen_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i
);

  localparam int unsigned RAM_AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0]      ram_q [DEPTH_WORDS];
  logic                 is_mmio;
  logic [1:0]           reg_sel;
  logic [RAM_AW-1:0]    ram_idx;
  logic                 ram_we;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 status_we;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [TX_DATA_W-1:0] fifo_head;
  logic                 ovf_q, ovf_d;
  logic [XLEN-1:0]      cycle_val;
  logic                 unused_bits;

  // Byte offset, bits above the decoded fields and upper store bits carry no meaning here
  assign unused_bits = ^{dmem_addr_i[1:0], dmem_addr_i[30:4], dmem_wdata_i[31:8]};

  // Split the access into RAM write, FIFO push/pop and STATUS write strobes
  always_comb begin
    is_mmio   = dmem_addr_i[MMIO_BIT];
    reg_sel   = dmem_addr_i[REG_SEL_LSB +: 2];
    ram_idx   = dmem_addr_i[RAM_AW+1:2];
    ram_we    = dmem_wen_i && !is_mmio && !rst_i;
    fifo_push = dmem_wen_i && is_mmio && (reg_sel == REG_TXDATA) && !rst_i;
    status_we = dmem_wen_i && is_mmio && (reg_sel == REG_STATUS) && !rst_i;
    fifo_pop  = !fifo_empty && tx_ready_i;
  end

  // Word RAM write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (ram_we) ram_q[ram_idx] <= dmem_wdata_i;
  end

  dmem_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TX_DATA_W)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (dmem_wdata_i[TX_DATA_W-1:0]),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sticky overflow: set by a refused push, cleared by software through STATUS
  always_comb begin
    ovf_d = ovf_q;
    if (fifo_push && fifo_full && !fifo_pop)          ovf_d = 1'b1;
    if (status_we && dmem_wdata_i[ST_CLR_OVF_BIT])    ovf_d = 1'b0;
  end

  // Overflow flag register
  always_ff @(posedge clk_i) begin
    if (rst_i) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [XLEN-1:0] cycle_q, cycle_d;

  // Free-running counter, wraps naturally at 2^32
  always_comb begin
    cycle_d = cycle_q + XLEN'(1);
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Zero-latency read mux across RAM and MMIO registers
  always_comb begin
    dmem_rdata_o = '0;
    if (!is_mmio) begin
      dmem_rdata_o = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        REG_CYCLE:  dmem_rdata_o = cycle_val;
        REG_STATUS: dmem_rdata_o = pack_status(ST_COUNT_W'(fifo_count), ovf_q,
                                               fifo_empty, fifo_full);
        default:    dmem_rdata_o = '0;
      endcase
    end
  end

  // Console side of the FIFO
  always_comb begin
    tx_valid_o = !fifo_empty;
    tx_data_o  = fifo_head;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage core; sits on the far end of the Memory stage's `dmem_wen/dmem_addr/dmem_wdata/dmem_rdata` port.
- Provides word-addressed RAM with combinational read and synchronous write.
- Provides a small MMIO window:
  - byte transmit FIFO drained by a valid/ready console interface,
  - free-running cycle counter,
  - status register.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, at least 2.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `dmem_wen_i`, in, 1: word write strobe for the current cycle.
- `dmem_addr_i`, in, 32: byte address (ALU result).
- `dmem_wdata_i`, in, 32: store data.
- `dmem_rdata_o`, out, 32: read data, combinational from `dmem_addr_i`.
- `tx_valid_o`, out, 1: FIFO head holds a byte.
- `tx_data_o`, out, 8: FIFO head byte.
- `tx_ready_i`, in, 1: consumer accepts the head byte this cycle.

## Operation
Decode:
- `addr[31]==0` selects RAM.
- `addr[31]==1` selects MMIO.
- `addr[1:0]` is ignored; all accesses are full-word.

RAM:
- Index is `addr[log2(DEPTH_WORDS)+1:2]`; upper bits are ignored, so out-of-range addresses alias (wrap).
- Write at the edge when `dmem_wen_i` is high.
- Read during a write to the same word returns the old contents.
- Contents are not reset.

MMIO, selected by `addr[3:2]`; `addr[30:4]` is ignored:
- 0 TXDATA:
  - Write pushes `wdata[7:0]`.
  - Read returns 0.
- 1 CYCLE:
  - Read returns the 32-bit counter.
  - Writes are ignored.
- 2 STATUS:
  - Read returns `{24'b0, count[3:0], 1'b0, overflow, empty, full}`.
  - Write with `wdata[2]=1` clears `overflow`.
- 3: reads 0, writes ignored.

TX FIFO:
- `tx_valid_o = (count != 0)`.
- `tx_data_o` is the head entry, and stays stable while `tx_valid_o && !tx_ready_i`.
- Pop when `tx_valid_o && tx_ready_i`.
- Push when full without a simultaneous pop:
  - byte is dropped,
  - `overflow` is set (sticky).
- Push and pop in the same cycle while full: push is accepted, count unchanged.
- Push and pop in the same cycle while non-empty and not full: count unchanged.
- Read/write pointers wrap modulo `FIFO_DEPTH`.
- `count` ranges 0..`FIFO_DEPTH`.

Cycle counter: increments by 1 every cycle outside reset; wraps `FFFF_FFFF -> 0000_0000`.

## Timing
Reset values:
- `tx_valid_o` = 0, `tx_data_o` = 0.
- count = 0, pointers = 0, `overflow` = 0, counter = 0.
- `dmem_rdata_o` follows the address combinationally.

Latency and handshake:
- Read latency is 0 cycles; the Memory stage samples `dmem_rdata_o` at the same edge.
- A write is visible to reads from the next cycle.
- A pushed byte appears on `tx_valid_o` the cycle after the push edge.
- A pop takes effect at the edge where `tx_valid_o && tx_ready_i`.

Reset mid-operation:
- Writes and pushes presented while `rst_i` is high are ignored.
- FIFO flushes; counter returns to 0.
- RAM keeps its contents.

## Configuration
`DMEM_CYCLE_COUNTER_EN`:
- Defined: the CYCLE register behaves as above.
- Undefined: no counter flops; reads of CYCLE return 0.

## Structure
Shared package `dmem_pkg`:
- MMIO base bit and register offsets (`TXDATA`, `CYCLE`, `STATUS`).
- STATUS bit positions.
- Default `FIFO_DEPTH`.

Sub-module `dmem_tx_fifo`:
- Parameterized synchronous FIFO with push/pop/full/empty/count.
- Owns the overflow-independent FIFO logic.
- The top level owns decode, RAM, counter and the `overflow` bit.

## Test plan
- Write `0xDEADBEEF` to `0x0000_0010`, then read `0x0000_0010` -> `0xDEADBEEF`; read `0x0000_1010` with `DEPTH_WORDS=1024` -> `0xDEADBEEF` (alias).
- Same-cycle write `0x1` and read of `0x20` holding `0x5` -> rdata `0x5` that cycle, `0x1` the next.
- Hold `tx_ready_i=0`, push `0x41,0x42,0x43,0x44,0x45` -> STATUS reads `0x45` (count 4, overflow, full); `tx_data_o=0x41` throughout.
- Then raise `tx_ready_i` -> bytes `41,42,43,44` each accepted on one edge, then `tx_valid_o=0`; STATUS reads `0x06` (empty, overflow); write STATUS `0x4` -> reads `0x02`.
- With FIFO full, push `0x46` while popping -> count stays 4; `0x46` emerges last.
- Release reset, read CYCLE 10 cycles later -> 10 (macro defined) or 0 (undefined); assert `rst_i` with 2 bytes queued -> next cycle `tx_valid_o=0` and RAM word retained.
